// File: rtl/pixel_config_readback_rx.sv
// Deserialiser for the pixel-configuration readback link: S_CLK/S_DATA -> DATA_WIDTH-bit FIFO writes.
// Optional build macro PIXEL_CFG_RX_WORD_CNT_EN adds a 16-bit WORD_CNT output counting written words.
module pixel_config_readback_rx #(
    parameter int DATA_WIDTH      = 15,
    parameter int SHIFT_DIRECTION = 1,
    parameter int CNT_WIDTH       = 4,
    parameter int TIMEOUT         = 255
) (
`ifdef PIXEL_CFG_RX_WORD_CNT_EN
    output logic [15:0]           WORD_CNT,
`endif
    input  logic                  CLK_IN,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  S_CLK,
    input  logic                  S_DATA,
    input  logic                  FULL,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  WR_FIFO,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    output logic                  FRAME_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [2:0]            s_clk_q, s_clk_d;
    logic [1:0]            s_data_q, s_data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_fifo_q, wr_fifo_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_err_q, frame_err_d;

    logic                  rise;
    logic                  s_bit;
    logic [DATA_WIDTH-1:0] sr_shifted;

    always_comb begin
        s_clk_d  = {s_clk_q[1:0], S_CLK};
        s_data_d = {s_data_q[0], S_DATA};
    end

    // Bit sampled with the same synchroniser depth as the clock, so it lines up with rise.
    assign rise  = s_clk_q[1] & ~s_clk_q[2];
    assign s_bit = s_data_q[1];

    generate
        if (DATA_WIDTH == 1) begin : g_w1
            assign sr_shifted = s_bit;
        end else if (SHIFT_DIRECTION != 0) begin : g_msb_first
            assign sr_shifted = {sr_q[DATA_WIDTH-2:0], s_bit};
        end else begin : g_lsb_first
            assign sr_shifted = {s_bit, sr_q[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        sr_d        = sr_q;
        data_out_d  = data_out_q;
        wr_fifo_d   = 1'b0;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tmo_d = '0;
                if (ENABLE && rise) begin
                    sr_d  = sr_shifted;
                    cnt_d = CNT_ONE;
                    if (DATA_WIDTH == 1) state_d = ST_WRITE;
                    else                 state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!ENABLE) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else if (rise) begin
                    sr_d  = sr_shifted;
                    cnt_d = cnt_q + CNT_ONE;
                    tmo_d = '0;
                    if (cnt_q == CNT_LAST) state_d = ST_WRITE;
                end else if (tmo_q >= TMO_LAST) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    tmo_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            ST_WRITE: begin
                if (FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_fifo_d  = 1'b1;
                    data_out_d = sr_q;
                end
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = ST_IDLE;
                // A rise here already belongs to the next word.
                if (ENABLE && rise) begin
                    sr_d  = sr_shifted;
                    cnt_d = CNT_ONE;
                    if (DATA_WIDTH == 1) state_d = ST_WRITE;
                    else                 state_d = ST_SHIFT;
                end
            end

            default: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            s_clk_q     <= '0;
            s_data_q    <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            sr_q        <= '0;
            data_out_q  <= '0;
            wr_fifo_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_clk_q     <= s_clk_d;
            s_data_q    <= s_data_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            sr_q        <= sr_d;
            data_out_q  <= data_out_d;
            wr_fifo_q   <= wr_fifo_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign DATA_OUT  = data_out_q;
    assign WR_FIFO   = wr_fifo_q;
    assign BUSY      = (state_q == ST_SHIFT);
    assign OVERFLOW  = overflow_q;
    assign FRAME_ERR = frame_err_q;

`ifdef PIXEL_CFG_RX_WORD_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q + {15'd0, wr_fifo_d};
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) word_cnt_q <= '0;
        else       word_cnt_q <= word_cnt_d;
    end

    assign WORD_CNT = word_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_config_readback_rx.sv
// Bench for pixel_config_readback_rx: MSB-first and LSB-first instances share one serial link.
// Expected words come from a bit-sequence model; FIFO writes are captured by a monitor.
module tb_pixel_config_readback_rx;
    localparam int DW  = 15;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst, en, s_clk, s_data, full;
    logic [DW-1:0] dout1, dout0;
    logic wr1, wr0, busy1, busy0, ovf1, ovf0, ferr1, ferr0;
`ifdef PIXEL_CFG_RX_WORD_CNT_EN
    logic [15:0] wc1, wc0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int exp_writes = 0;
    int dbl_wr = 0;
    logic wr1_prev = 1'b0;
    logic wr0_prev = 1'b0;
    logic exp_ovf = 1'b0;

    int q1_data[$], q1_cyc[$], q0_data[$];
    int exp1_q[$], exp0_q[$], exp_cyc_q[$];

    pixel_config_readback_rx #(.DATA_WIDTH(DW), .SHIFT_DIRECTION(1), .CNT_WIDTH(4), .TIMEOUT(TMO)) dut1 (
`ifdef PIXEL_CFG_RX_WORD_CNT_EN
        .WORD_CNT(wc1),
`endif
        .CLK_IN(clk), .RESET(rst), .ENABLE(en), .S_CLK(s_clk), .S_DATA(s_data), .FULL(full),
        .DATA_OUT(dout1), .WR_FIFO(wr1), .BUSY(busy1), .OVERFLOW(ovf1), .FRAME_ERR(ferr1)
    );

    pixel_config_readback_rx #(.DATA_WIDTH(DW), .SHIFT_DIRECTION(0), .CNT_WIDTH(4), .TIMEOUT(TMO)) dut0 (
`ifdef PIXEL_CFG_RX_WORD_CNT_EN
        .WORD_CNT(wc0),
`endif
        .CLK_IN(clk), .RESET(rst), .ENABLE(en), .S_CLK(s_clk), .S_DATA(s_data), .FULL(full),
        .DATA_OUT(dout0), .WR_FIFO(wr0), .BUSY(busy0), .OVERFLOW(ovf0), .FRAME_ERR(ferr0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every FIFO write with the cycle it appeared in.
    always @(negedge clk) begin
        if (wr1) begin
            q1_data.push_back(int'(dout1));
            q1_cyc.push_back(cyc);
            $display("write dut_msb: data=%h cycle=%0d", dout1, cyc);
        end
        if (wr0) begin
            q0_data.push_back(int'(dout0));
            $display("write dut_lsb: data=%h cycle=%0d", dout0, cyc);
        end
        if ((wr1 && wr1_prev) || (wr0 && wr0_prev)) dbl_wr++;
        wr1_prev = wr1;
        wr0_prev = wr0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One serial bit: 2 CLK_IN cycles high, 2 low.
    task automatic send_bit(input logic b);
        s_data    = b;
        s_clk     = 1'b1;
        last_rise = cyc;
        tick(2);
        s_clk = 1'b0;
        tick(2);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[DW-1-i]);
    endtask

    // Reference: value assembled from the wire bit sequence (w sent MSB first).
    function automatic int model_word(input logic [DW-1:0] w, input bit first_is_msb);
        int v = 0;
        for (int i = 0; i < DW; i++) begin
            int b = int'((w >> (DW - 1 - i)) & 1);
            if (first_is_msb) v = v * 2 + b;
            else              v = v + (b << i);
        end
        return v;
    endfunction

    task automatic send_modelled(input logic [DW-1:0] w, input logic full_val);
        full = full_val;
        send_word(w, DW);
        if (!full_val) begin
            exp1_q.push_back(model_word(w, 1'b1));
            exp0_q.push_back(model_word(w, 1'b0));
            exp_cyc_q.push_back(last_rise + 4);
            exp_writes++;
        end else begin
            exp_ovf = 1'b1;
        end
        $display("sent word %h full=%0b", w, full_val);
    endtask

    task automatic verify_all(input string tag);
        chk({tag, ".count_msb"}, q1_data.size(), exp1_q.size());
        chk({tag, ".count_lsb"}, q0_data.size(), exp0_q.size());
        while (q1_data.size() > 0 && exp1_q.size() > 0) begin
            chk({tag, ".data_msb"}, q1_data.pop_front(), exp1_q.pop_front());
            chk({tag, ".latency"}, q1_cyc.pop_front(), exp_cyc_q.pop_front());
        end
        while (q0_data.size() > 0 && exp0_q.size() > 0)
            chk({tag, ".data_lsb"}, q0_data.pop_front(), exp0_q.pop_front());
        q1_data.delete(); q1_cyc.delete(); q0_data.delete();
        exp1_q.delete(); exp0_q.delete(); exp_cyc_q.delete();
    endtask

    initial begin
        int waited;
        int elapsed;
        logic [DW-1:0] w;

        rst = 1'b1; en = 1'b1; full = 1'b0; s_clk = 1'b0; s_data = 1'b1;

        // Reset with S_CLK toggling.
        tick(1); s_clk = 1'b1;
        tick(1); s_clk = 1'b0;
        tick(1); s_clk = 1'b1;
        tick(1); rst = 1'b0; s_clk = 1'b0;
        tick(4);
        chk("reset.data_out", dout1, '0);
        chk("reset.wr_fifo", wr1, 1'b0);
        chk("reset.busy", busy1 | busy0, 1'b0);
        chk("reset.overflow", ovf1 | ovf0, 1'b0);
        chk("reset.frame_err", ferr1 | ferr0, 1'b0);
        chk("reset.no_write", q1_data.size() + q0_data.size(), 0);
`ifdef PIXEL_CFG_RX_WORD_CNT_EN
        chk("reset.word_cnt", wc1, 16'd0);
`endif

        // Directed word with the known bit pattern.
        send_word(15'b110100101011001, DW);
        exp1_q.push_back(32'h6959);
        exp0_q.push_back(32'h4D4B);
        exp_cyc_q.push_back(last_rise + 4);
        exp_writes++;
        tick(2);
        verify_all("single");
        chk("single.busy_after", busy1 | busy0, 1'b0);

        // Back-to-back words without a gap.
        send_modelled(15'h7FFF, 1'b0);
        send_modelled(15'h0001, 1'b0);
        tick(2);
        verify_all("b2b");
        chk("b2b.frame_err", ferr1 | ferr0, 1'b0);

        // Word dropped because FIFO full, then a normal word.
        send_modelled(DW'($urandom), 1'b1);
        tick(2);
        full = 1'b0;
        verify_all("full");
        chk("full.overflow_msb", ovf1, 1'b1);
        chk("full.overflow_lsb", ovf0, 1'b1);
        send_modelled(DW'($urandom), 1'b0);
        tick(2);
        verify_all("after_full");
        chk("after_full.overflow_sticky", ovf1 & ovf0, 1'b1);

        // ENABLE dropped mid-word: abort quietly.
        send_word(DW'($urandom), 7);
        chk("abort.busy_before", busy1, 1'b1);
        en = 1'b0;
        tick(3);
        chk("abort.busy", busy1 | busy0, 1'b0);
        en = 1'b1;
        tick(2);
        verify_all("abort");
        chk("abort.frame_err", ferr1 | ferr0, 1'b0);
        send_modelled(DW'($urandom), 1'b0);
        tick(2);
        verify_all("after_abort");

        // S_CLK stalls mid-word: partial word discarded by timeout.
        send_word(DW'($urandom), 7);
        waited = 0;
        while (!ferr1 && waited < 400) begin
            tick(1);
            waited++;
        end
        elapsed = cyc - last_rise;
        chk("tmo.frame_err_msb", ferr1, 1'b1);
        chk("tmo.frame_err_lsb", ferr0, 1'b1);
        chk("tmo.window", (elapsed >= TMO && elapsed <= TMO + 4) ? 1 : 0, 1);
        chk("tmo.busy", busy1 | busy0, 1'b0);
        verify_all("tmo");
        send_modelled(DW'($urandom), 1'b0);
        tick(2);
        verify_all("after_tmo");
        chk("after_tmo.frame_err_sticky", ferr1 & ferr0, 1'b1);

        // Random words with random FIFO back-pressure.
        for (int i = 0; i < 8; i++) begin
            w = DW'($urandom);
            send_modelled(w, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            tick(2);
            full = 1'b0;
            verify_all($sformatf("rand%0d", i));
            chk($sformatf("rand%0d.overflow", i), ovf1, exp_ovf);
        end

        chk("no_double_write", dbl_wr, 0);
`ifdef PIXEL_CFG_RX_WORD_CNT_EN
        chk("word_cnt_msb", wc1, 16'(exp_writes));
        chk("word_cnt_lsb", wc0, 16'(exp_writes));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
